// File: rtl/vga_fb_reader.sv
// vga_fb_reader
// Turns the timing controller's (x_idx, y_idx) stream into framebuffer read
// addresses with 2^SCALE_SHIFT pixel replication in both axes, issues the
// read to a synchronous RAM and re-aligns the syncs/enable with the returned
// pixel so everything leaves the block on the same cycle.
//
// Ports
//   clk, reset          pixel clock, asynchronous active-high reset
//   h_sync_in/v_sync_in syncs from the timing controller (polarity untouched)
//   video_enable_in     active-region flag from the timing controller
//   x_idx/y_idx         current column / line
//   fb_addr, fb_rd_en   registered framebuffer read request
//   fb_rd_data          RAM data, valid RD_LATENCY cycles after the request
//   rgb                 pixel out, 0 outside the active region
//   h_sync/v_sync       delayed syncs
//   video_enable        delayed enable
//   frame_start         one-cycle pulse on output pixel (0,0)
//
// Latency from inputs to rgb/h_sync/v_sync/video_enable/frame_start is
// RD_LATENCY+2 cycles; fb_addr/fb_rd_en follow the inputs by one cycle.
module vga_fb_reader #(
    parameter int H_PIXELS    = 1920,
    parameter int V_PIXELS    = 1080,
    parameter int SCALE_SHIFT = 3,
    parameter int FB_WIDTH    = H_PIXELS >> SCALE_SHIFT,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 12,
    parameter int RD_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              video_enable_in,
    input  logic [11:0]       x_idx,
    input  logic [11:0]       y_idx,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd_en,
    input  logic [DATA_W-1:0] fb_rd_data,
    output logic [DATA_W-1:0] rgb,
    output logic              h_sync,
    output logic              v_sync,
    output logic              video_enable,
    output logic              frame_start
);

    localparam int                PIPE_N  = RD_LATENCY + 2;
    localparam logic [ADDR_W-1:0] FB_STEP = ADDR_W'(FB_WIDTH);
    localparam logic [11:0]       H_LIM   = 12'(H_PIXELS);
    localparam logic [11:0]       V_LIM   = 12'(V_PIXELS);

    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [11:0]       prev_y_q;
    logic              armed_q, armed_d;
    logic              first_prev_q;
    logic              en_s, first_pix_s, frame_pulse_s;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              fb_rd_en_q;
    logic [PIPE_N-1:0] hs_pipe_q, vs_pipe_q, en_pipe_q, fs_pipe_q;
    logic [DATA_W-1:0] rgb_q, rgb_d;

    // Row base tracking: step by one framebuffer row every 2^SCALE_SHIFT lines
    always_comb begin
        row_base_d = row_base_q;
        if (y_idx != prev_y_q) begin
            if (y_idx == 12'd0) begin
                row_base_d = {ADDR_W{1'b0}};
            end else if (y_idx[SCALE_SHIFT-1:0] == {SCALE_SHIFT{1'b0}}) begin
                row_base_d = row_base_q + FB_STEP;
            end else begin
                row_base_d = row_base_q;
            end
        end else begin
            row_base_d = row_base_q;
        end
    end

    // Address, enable qualification and output pixel selection
    always_comb begin
        // The new row base is used so the first pixel of a row addresses the new row.
        fb_addr_d     = row_base_d + ADDR_W'(x_idx >> SCALE_SHIFT);
        // After reset nothing is shown until a frame top arrives, so the
        // row base is known to be in step with the picture.
        armed_d       = armed_q | (y_idx == 12'd0);
        en_s          = video_enable_in & (armed_q | (y_idx == 12'd0)) &
                        (x_idx < H_LIM) & (y_idx < V_LIM);
        first_pix_s   = en_s & (x_idx == 12'd0) & (y_idx == 12'd0);
        // Edge-detect so a held (0,0) produces a single pulse.
        frame_pulse_s = first_pix_s & ~first_prev_q;
        rgb_d         = {DATA_W{1'b0}};
        if (en_pipe_q[RD_LATENCY]) begin
            rgb_d = fb_rd_data;
        end else begin
            rgb_d = {DATA_W{1'b0}};
        end
    end

    // State, read request and matched delay line registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base_q   <= {ADDR_W{1'b0}};
            prev_y_q     <= 12'hFFF;
            armed_q      <= 1'b0;
            first_prev_q <= 1'b0;
            fb_addr_q    <= {ADDR_W{1'b0}};
            fb_rd_en_q   <= 1'b0;
            hs_pipe_q    <= {PIPE_N{1'b0}};
            vs_pipe_q    <= {PIPE_N{1'b0}};
            en_pipe_q    <= {PIPE_N{1'b0}};
            fs_pipe_q    <= {PIPE_N{1'b0}};
            rgb_q        <= {DATA_W{1'b0}};
        end else begin
            row_base_q   <= row_base_d;
            prev_y_q     <= y_idx;
            armed_q      <= armed_d;
            first_prev_q <= first_pix_s;
            fb_addr_q    <= fb_addr_d;
            fb_rd_en_q   <= en_s;
            hs_pipe_q    <= {hs_pipe_q[PIPE_N-2:0], h_sync_in};
            vs_pipe_q    <= {vs_pipe_q[PIPE_N-2:0], v_sync_in};
            en_pipe_q    <= {en_pipe_q[PIPE_N-2:0], en_s};
            fs_pipe_q    <= {fs_pipe_q[PIPE_N-2:0], frame_pulse_s};
            rgb_q        <= rgb_d;
        end
    end

    assign fb_addr      = fb_addr_q;
    assign fb_rd_en     = fb_rd_en_q;
    assign rgb          = rgb_q;
    assign h_sync       = hs_pipe_q[PIPE_N-1];
    assign v_sync       = vs_pipe_q[PIPE_N-1];
    assign video_enable = en_pipe_q[PIPE_N-1];
    assign frame_start  = fs_pipe_q[PIPE_N-1];

endmodule

// File: tb/tb_vga_fb_reader.sv
module tb_vga_fb_reader;

    logic        clk;
    logic        reset;
    logic        h_sync_in, v_sync_in, video_enable_in;
    logic [11:0] x_idx, y_idx;
    logic [15:0] fb_addr;
    logic        fb_rd_en;
    logic [11:0] fb_rd_data;
    logic [11:0] rgb;
    logic        h_sync, v_sync, video_enable, frame_start;

    int tests = 0;
    int fails = 0;

    vga_fb_reader dut (
        .clk             (clk),
        .reset           (reset),
        .h_sync_in       (h_sync_in),
        .v_sync_in       (v_sync_in),
        .video_enable_in (video_enable_in),
        .x_idx           (x_idx),
        .y_idx           (y_idx),
        .fb_addr         (fb_addr),
        .fb_rd_en        (fb_rd_en),
        .fb_rd_data      (fb_rd_data),
        .rgb             (rgb),
        .h_sync          (h_sync),
        .v_sync          (v_sync),
        .video_enable    (video_enable),
        .frame_start     (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: latency 2, returns data = address, 12'hFFF when not read
    logic [11:0] ram_q1, ram_q2;
    always @(posedge clk) begin
        ram_q1 <= fb_rd_en ? fb_addr[11:0] : 12'hFFF;
        ram_q2 <= ram_q1;
    end
    assign fb_rd_data = ram_q2;

    typedef struct {
        logic        ve;
        logic        hs;
        logic        vs;
        logic [11:0] x;
        logic [11:0] y;
        logic [15:0] addr;
        logic        fs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ve, input logic hs, input logic vs,
                       input int x, input int y, input int addr, input logic fs);
        vec_t v;
        v.ve = ve; v.hs = hs; v.vs = vs;
        v.x = 12'(x); v.y = 12'(y); v.addr = 16'(addr); v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic ve, input logic hs, input logic vs,
                         input logic [11:0] x, input logic [11:0] y);
        video_enable_in = ve; h_sync_in = hs; v_sync_in = vs;
        x_idx = x; y_idx = y;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " rgb"},   32'(rgb), 32'd0);
        check({tag, " addr"},  32'(fb_addr), 32'd0);
        check({tag, " rd_en"}, 32'(fb_rd_en), 32'd0);
        check({tag, " hs"},    32'(h_sync), 32'd0);
        check({tag, " vs"},    32'(v_sync), 32'd0);
        check({tag, " ve"},    32'(video_enable), 32'd0);
        check({tag, " fs"},    32'(frame_start), 32'd0);
    endtask

    initial begin
        vec_t   o;
        int     n;
        logic [11:0] exp_rgb;

        // ve hs vs x y addr fs
        add(1,0,1, 0,0, 0,1);  add(1,1,1, 1,0, 0,0);  add(1,0,1, 2,0, 0,0);
        add(1,1,1, 3,0, 0,0);  add(1,0,0, 4,0, 0,0);  add(1,1,0, 5,0, 0,0);
        add(1,0,0, 6,0, 0,0);  add(1,1,0, 7,0, 0,0);  add(1,0,0, 8,0, 1,0);
        add(1,1,0, 9,0, 1,0);  add(1,0,0,10,0, 1,0);  add(1,1,0,11,0, 1,0);
        add(1,0,0,12,0, 1,0);  add(1,1,0,13,0, 1,0);  add(1,0,0,14,0, 1,0);
        add(1,1,0,15,0, 1,0);
        add(0,1,0,16,0, 2,0);  add(0,1,0,17,0, 2,0);             // blanking
        add(1,0,0,16,7, 2,0);  add(1,1,0,16,8, 242,0);           // row step
        add(1,0,0,24,8, 243,0); add(1,1,0,16,9, 242,0);
        add(1,0,0, 0,16, 480,0); add(1,1,0, 8,16, 481,0);
        add(0,1,0,1920,16, 720,0);
        add(1,0,0, 0,1079, 480,0); add(0,0,1, 0,1124, 480,0);    // frame wrap
        add(1,0,0, 0,0, 0,1);  add(1,1,0, 0,0, 0,0);  add(1,0,0, 0,0, 0,0);
        add(1,1,0, 1,0, 0,0);  add(1,0,0, 8,0, 1,0);
        add(0,0,0, 9,0, 1,0);  add(0,0,0,10,0, 1,0);  add(0,0,0,11,0, 1,0);
        n = vecs.size();

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Table: fb_addr one cycle after its input, outputs four cycles after
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk);
            if (i < n) drive(vecs[i].ve, vecs[i].hs, vecs[i].vs, vecs[i].x, vecs[i].y);
            else       drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
            @(posedge clk);
            #1;
            if (i < n) begin
                check($sformatf("v%0d addr", i), 32'(fb_addr), 32'(vecs[i].addr));
                check($sformatf("v%0d rd_en", i), 32'(fb_rd_en), 32'(vecs[i].ve));
            end
            if (i >= 3) begin
                o = vecs[i-3];
                exp_rgb = o.ve ? o.addr[11:0] : 12'h000;
                check($sformatf("v%0d rgb", i-3), 32'(rgb), 32'(exp_rgb));
                check($sformatf("v%0d hs", i-3), 32'(h_sync), 32'(o.hs));
                check($sformatf("v%0d vs", i-3), 32'(v_sync), 32'(o.vs));
                check($sformatf("v%0d ve", i-3), 32'(video_enable), 32'(o.ve));
                check($sformatf("v%0d fs", i-3), 32'(frame_start), 32'(o.fs));
            end
        end

        // Reset mid-line at x=500, y=300
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 12'd500, 12'd300);
        repeat (5) @(posedge clk);
        #1;
        check("midline addr", 32'(fb_addr), 32'd62);
        check("midline rgb", 32'(rgb), 32'd62);
        check("midline hs", 32'(h_sync), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("async reset");
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 12'd501, 12'd300);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset rgb c%0d", k), 32'(rgb), 32'd0);
            check($sformatf("post-reset rd_en c%0d", k), 32'(fb_rd_en), 32'd0);
            check($sformatf("post-reset ve c%0d", k), 32'(video_enable), 32'd0);
        end

        // New frame after reset: addresses restart from 0
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0)      drive(1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
            else if (k == 1) drive(1'b1, 1'b0, 1'b0, 12'd8, 12'd0);
            else             drive(1'b0, 1'b0, 1'b0, 12'd9, 12'd0);
            @(posedge clk);
            #1;
            if (k == 0) begin
                check("restart addr0", 32'(fb_addr), 32'd0);
                check("restart rd_en0", 32'(fb_rd_en), 32'd1);
            end
            if (k == 1) check("restart addr1", 32'(fb_addr), 32'd1);
            if (k == 3) begin
                check("restart fs", 32'(frame_start), 32'd1);
                check("restart ve", 32'(video_enable), 32'd1);
                check("restart rgb0", 32'(rgb), 32'd0);
            end
            if (k == 4) begin
                check("restart rgb1", 32'(rgb), 32'd1);
                check("restart fs off", 32'(frame_start), 32'd0);
            end
            if (k == 5) check("restart rgb blank", 32'(rgb), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
